hack_cpu_mc: RTL and testbench
==============================

Name: hack_cpu_mc

Overview:
Parametrised, multi-cycle Hack-ISA CPU for the teocs platform. It replaces the single-cycle core, which had a fixed instruction input and lookup-table ALU. This core fetches over its own instruction-memory handshake, reads and writes data memory through a req/ack port, and decodes the ALU from the six control bits zx/nx/zy/ny/f/no. It sits between instruction ROM and data RAM/MMIO in the platform top.

Parameters:
DATA_W, 16, datapath, A/D register and instruction width (min 16)
ADDR_W, 15, data-memory address width; dmem_addr = A[ADDR_W-1:0]
PC_W, 15, program-counter width; wraps modulo 2^PC_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_data  in  DATA_W  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = write, 0 = read; valid while dmem_req
dmem_addr  out  ADDR_W  data address
dmem_wdata  out  DATA_W  write data
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
dmem_ack  in  1  data access complete
pc  out  PC_W  current program counter
halted  out  1  halt detected (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - A, D, IR, MDR, pc, and all outputs are 0.
  - State = S_RST.
  - A request drops in the same instant, even mid-handshake.
- FSM: S_RST -> S_FETCH -> S_DEC -> (S_MRD) -> S_EXEC -> (S_MWR) -> S_FETCH.
- S_RST: all req low; exits to S_FETCH on the first clk edge after release.
- S_FETCH: imem_req=1, imem_addr=pc.
  - Held stable until imem_ack is sampled 1.
  - Then IR <= imem_data; go to S_DEC.
- Handshake: acks are ignored when the matching req is low. Ack in the same cycle as req rising is legal (zero wait).
- S_DEC, IR[DATA_W-1]=0 (A-instruction):
  - A <= zero-extended IR[DATA_W-2:0].
  - pc <= pc+1.
  - Go to S_FETCH.
- S_DEC, C-instruction:
  - Bits used: a=IR[12], c=IR[11:6], dest=IR[5:3] (A,D,M), jump=IR[2:0] (lt,eq,gt).
  - Bits IR[DATA_W-2:13] are ignored.
  - If a=1: go to S_MRD. Else go to S_EXEC.
- S_MRD: dmem_req=1, dmem_we=0, dmem_addr=A.
  - On dmem_ack: MDR <= dmem_rdata; go to S_EXEC.
- S_EXEC ALU (x=D, y = a ? MDR : A):
  - if zx then x=0; if nx then x=~x.
  - Same for y with zy/ny.
  - out = f ? x+y : x&y; if no then out=~out.
  - Arithmetic is modulo 2^DATA_W. All 64 c codes are legal; there is no "not implemented" case.
- S_EXEC flags: zr = (out==0); ng = out[DATA_W-1] (signed compare).
- S_EXEC jump:
  - Taken when (lt&ng) | (eq&zr) | (gt&~ng&~zr).
  - If taken, pc <= old A[PC_W-1:0]; else pc <= pc+1.
- S_EXEC writes:
  - Write address latched from old A.
  - dest A -> A <= out; dest D -> D <= out.
  - These updates happen at the S_EXEC edge, after the jump target and write address have used old A.
  - dest M: go to S_MWR. Else go to S_FETCH.
- S_MWR: dmem_req=1, dmem_we=1, dmem_addr=latched old A, dmem_wdata=out (latched).
  - Held stable until dmem_ack; then go to S_FETCH.
- Cycle counts with zero-wait acks:
  - A-instr: 2 cycles.
  - C-instr: 3 cycles, +1 for M read, +1 for M write.
- pc = PC_W'max with increment wraps to 0.
- dmem_req and imem_req are never high together.

Optional Feature:
HALT_DETECT_EN
- With it: a flag prev_a is set when the last retired instruction was an A-instruction.
  - If a taken jump in S_EXEC has prev_a=1 and target == pc-1 (the canonical "(END) @END; 0;JMP" loop), then halted <= 1 and state -> S_HALT.
  - S_HALT keeps all reqs at 0 and is left only via reset.
- Without it: halted is tied to 0 and the loop executes forever.

Test Plan:
- ROM "@5; D=A; @7; M=D", zero-wait -> exactly one dmem write: addr 7, wdata 5, we=1; D=5; pc=4.
- D=5, A=3, "D=D-A" (c=010011) -> D=2. Then "D=-1" (c=111010) -> D=16'hFFFF, ng=1.
- D=0, "@10; D;JEQ" -> pc=10. Repeat with D=1 -> pc=prev+1. "@20; 0;JMP" -> pc=20 regardless.
- RAM[100]=42, "@100; D=M+1" -> one read (we=0, addr 100), D=43. imem_ack delayed 3 cycles -> imem_req/imem_addr stable, no state change.
- reset pulled low during S_MWR with dmem_ack withheld -> dmem_req=0 immediately. After release: one idle cycle, then fetch from pc=0.
- HALT_DETECT_EN defined, "@4" at addr 4, "0;JMP" at addr 5 -> halted=1, imem_req stays 0 for 100 cycles. Macro undefined -> halted=0, pc alternates 4,5.

Source files
------------

// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory bus of the multi-cycle Hack core.
// master = CPU side, slave = memory side; acks are only meaningful while the matching req is high.
interface hack_cpu_mc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int PC_W   = 15
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_data, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_data, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: fetch/decode/(mem read)/execute/(mem write); optional HALT_DETECT_EN stops on "@L; 0;JMP" at L.
// Latency: A-instr 2 cycles, C-instr 3 (+1 M read, +1 M write) with zero-wait acks; every req is held stable until its ack.
module hack_cpu_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int PC_W   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hack_cpu_mc_if.master     bus,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_halted
);
    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DEC, S_MRD, S_EXEC, S_MWR, S_HALT
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_a, r_d, r_ir, r_mdr, r_wdata;
    logic [ADDR_W-1:0]  r_waddr;
    logic [PC_W-1:0]    r_pc;

    logic               w_is_c, w_abit, w_zr, w_ng, w_take, w_halt;
    logic [5:0]         w_c;
    logic [2:0]         w_dest, w_jmp;
    logic [DATA_W-1:0]  w_x, w_y, w_out;
    logic [PC_W-1:0]    w_target, w_pc_inc;

    assign w_is_c   = r_ir[DATA_W-1];
    assign w_abit   = r_ir[12];
    assign w_c      = r_ir[11:6];
    assign w_dest   = r_ir[5:3];
    assign w_jmp    = r_ir[2:0];
    assign w_target = r_a[PC_W-1:0];
    assign w_pc_inc = r_pc + PC_ONE;
    assign o_pc     = r_pc;

    // ALU decoded directly from zx/nx/zy/ny/f/no
    always_comb begin
        w_x = r_d;
        if (w_c[5]) w_x = '0;
        if (w_c[4]) w_x = ~w_x;
        w_y = w_abit ? r_mdr : r_a;
        if (w_c[3]) w_y = '0;
        if (w_c[2]) w_y = ~w_y;
        w_out = w_c[1] ? (w_x + w_y) : (w_x & w_y);
        if (w_c[0]) w_out = ~w_out;
    end

    assign w_zr   = (w_out == '0);
    assign w_ng   = w_out[DATA_W-1];
    assign w_take = (w_jmp[2] & w_ng) | (w_jmp[1] & w_zr) | (w_jmp[0] & ~w_ng & ~w_zr);

`ifdef HALT_DETECT_EN
    logic            r_prev_a, r_halted;
    logic [PC_W-1:0] w_pc_dec;

    assign w_pc_dec = r_pc - PC_ONE;
    assign w_halt   = w_take & r_prev_a & (w_target == w_pc_dec);
    assign o_halted = r_halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_a <= 1'b0;
            r_halted <= 1'b0;
        end else if (r_state == S_DEC && !w_is_c) begin
            r_prev_a <= 1'b1;
        end else if (r_state == S_EXEC) begin
            r_prev_a <= 1'b0;
            if (w_halt) r_halted <= 1'b1;
        end
    end
`else
    assign w_halt   = 1'b0;
    assign o_halted = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_RST;
        else          r_state <= w_state_nxt;
    end

    // Bus outputs decode from state alone so reset drops every req asynchronously
    always_comb begin
        w_state_nxt    = r_state;
        bus.imem_req   = 1'b0;
        bus.imem_addr  = r_pc;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        case (r_state)
            S_RST:   w_state_nxt = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) w_state_nxt = S_DEC;
            end
            S_DEC: begin
                if (!w_is_c)     w_state_nxt = S_FETCH;
                else if (w_abit) w_state_nxt = S_MRD;
                else             w_state_nxt = S_EXEC;
            end
            S_MRD: begin
                bus.dmem_req  = 1'b1;
                bus.dmem_addr = r_a[ADDR_W-1:0];
                if (bus.dmem_ack) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_halt)         w_state_nxt = S_HALT;
                else if (w_dest[0]) w_state_nxt = S_MWR;
                else                w_state_nxt = S_FETCH;
            end
            S_MWR: begin
                bus.dmem_req   = 1'b1;
                bus.dmem_we    = 1'b1;
                bus.dmem_addr  = r_waddr;
                bus.dmem_wdata = r_wdata;
                if (bus.dmem_ack) w_state_nxt = S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
            r_mdr   <= '0;
            r_pc    <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (bus.imem_ack) r_ir <= bus.imem_data;
                S_DEC: begin
                    if (!w_is_c) begin
                        r_a  <= {1'b0, r_ir[DATA_W-2:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                S_MRD: if (bus.dmem_ack) r_mdr <= bus.dmem_rdata;
                S_EXEC: begin
                    // Jump target and store address take A before this edge overwrites it
                    r_pc    <= w_take ? w_target : w_pc_inc;
                    r_waddr <= r_a[ADDR_W-1:0];
                    r_wdata <= w_out;
                    if (w_dest[2]) r_a <= w_out;
                    if (w_dest[1]) r_d <= w_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: small ROM/RAM responders plus hand-encoded Hack programs.
module tb_hack_cpu_mc;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int PW = 15;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] pc;
    logic          halted;

    hack_cpu_mc_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) bus ();

    hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus),
        .o_pc     (pc),
        .o_halted (halted)
    );

    always #5 clk = ~clk;

    logic [15:0]   rom [0:63];
    logic [15:0]   rom_top = 16'h0000;
    logic [15:0]   ram [0:127];
    int            fetches_left = 0, imem_delay = 0, iwait = 0, stalled = 0;
    int            addr5_fetches = 0, unstable = 0, overlap = 0, dmem_hold = 0;
    int            wr_cnt = 0, rd_cnt = 0;
    logic [PW-1:0] iaddr_prev = '0, pc_prev = '0;
    logic [AW-1:0] last_waddr = '0, first_raddr = '0;
    logic [15:0]   last_wdata = '0;
    logic          last_we = 1'b0;
    int            checks = 0, failures = 0;
    int            cyc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responders: decide acks on the falling edge, sampled by the DUT on the next rising edge
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_data  = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req && bus.dmem_req) overlap++;
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (bus.imem_req) begin
                if (iwait > 0 && (bus.imem_addr !== iaddr_prev || pc !== pc_prev)) unstable++;
                iaddr_prev = bus.imem_addr;
                pc_prev    = pc;
                if (fetches_left == 0) begin
                    stalled = 1;
                end else if (iwait >= imem_delay) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = (bus.imem_addr == 15'h7FFF) ? rom_top : rom[bus.imem_addr[5:0]];
                    if (bus.imem_addr == 15'd5) addr5_fetches++;
                    fetches_left--;
                    iwait = 0;
                end else begin
                    iwait++;
                end
            end else begin
                iwait = 0;
            end
            if (bus.dmem_req && dmem_hold == 0) begin
                bus.dmem_ack = 1'b1;
                last_we      = bus.dmem_we;
                if (bus.dmem_we) begin
                    ram[bus.dmem_addr[6:0]] = bus.dmem_wdata;
                    last_waddr = bus.dmem_addr;
                    last_wdata = bus.dmem_wdata;
                    wr_cnt++;
                end else begin
                    bus.dmem_rdata = ram[bus.dmem_addr[6:0]];
                    if (rd_cnt == 0) first_raddr = bus.dmem_addr;
                    rd_cnt++;
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 64; i++)  rom[i] = 16'h0000;
        for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
    endtask

    task automatic start(input int nf, input int idly);
        rst_n = 1'b0;
        tick;
        tick;
        fetches_left  = nf;
        imem_delay    = idly;
        stalled       = 0;
        wr_cnt        = 0;
        rd_cnt        = 0;
        addr5_fetches = 0;
        unstable      = 0;
        dmem_hold     = 0;
        last_we       = 1'b0;
        rst_n         = 1'b1;
    endtask

    task automatic run_to_stall(input int bound, output int n);
        n = 0;
        while (stalled == 0 && n < bound) begin
            tick;
            n++;
        end
        check_val("stall_reached", stalled, 1);
    endtask

    initial begin
        clear_mem();
        rst_n = 1'b0;
        tick;
        tick;
        check_val("rst_imem_req",   bus.imem_req,   0);
        check_val("rst_dmem_req",   bus.dmem_req,   0);
        check_val("rst_dmem_we",    bus.dmem_we,    0);
        check_val("rst_dmem_addr",  bus.dmem_addr,  0);
        check_val("rst_dmem_wdata", bus.dmem_wdata, 0);
        check_val("rst_pc",         pc,             0);
        check_val("rst_halted",     halted,         0);

        // @5; D=A; @7; M=D
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
        start(4, 0);
        run_to_stall(100, cyc);
        check_val("t1_cycles", cyc,        12);
        check_val("t1_writes", wr_cnt,     1);
        check_val("t1_reads",  rd_cnt,     0);
        check_val("t1_waddr",  last_waddr, 7);
        check_val("t1_wdata",  last_wdata, 5);
        check_val("t1_we",     last_we,    1);
        check_val("t1_pc",     pc,         4);

        // D=5; A=3; D=D-A -> ram[8]; D=-1 -> ram[9]; @12; D;JLT
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE4D0;
        rom[4] = 16'h0008; rom[5] = 16'hE308; rom[6] = 16'hEE90; rom[7] = 16'h0009;
        rom[8] = 16'hE308; rom[9] = 16'h000C; rom[10] = 16'hE304;
        start(11, 0);
        run_to_stall(200, cyc);
        check_val("t2_sub",    ram[8], 16'h0002);
        check_val("t2_neg1",   ram[9], 16'hFFFF);
        check_val("t2_jlt_pc", pc,     12);

        // D=0; @10; D;JEQ taken, then D=1 not taken
        clear_mem();
        rom[0] = 16'h0000; rom[1] = 16'hEC10; rom[2] = 16'h000A; rom[3] = 16'hE302;
        start(4, 0);
        run_to_stall(100, cyc);
        check_val("t3_jeq_taken", pc, 10);
        rom[0] = 16'h0001;
        start(4, 0);
        run_to_stall(100, cyc);
        check_val("t3_jeq_not", pc, 4);

        // @20; 0;JMP
        rom[0] = 16'h0014; rom[1] = 16'hEA87;
        start(2, 0);
        run_to_stall(100, cyc);
        check_val("t3_jmp", pc, 20);

        // Jump to the last pc, whose A-instruction wraps pc to 0
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom_top = 16'h0005;
        start(3, 0);
        run_to_stall(100, cyc);
        check_val("t3_wrap_pc",     pc,  0);
        check_val("t3_wrap_cycles", cyc, 8);

        // @100; D=M+1; @101; M=D; AM=M+1; M=D with slow instruction memory
        clear_mem();
        ram[100] = 16'd42;
        rom[0] = 16'h0064; rom[1] = 16'hFDD0; rom[2] = 16'h0065; rom[3] = 16'hE308;
        rom[4] = 16'hFDE8; rom[5] = 16'hE308;
        start(6, 3);
        run_to_stall(300, cyc);
        check_val("t4_cycles",   cyc,         40);
        check_val("t4_reads",    rd_cnt,      2);
        check_val("t4_raddr",    first_raddr, 100);
        check_val("t4_mplus1",   ram[101],    16'd44);
        check_val("t4_new_a_st", ram[44],     16'd43);
        check_val("t4_writes",   wr_cnt,      3);
        check_val("t4_stable",   unstable,    0);

        // Reset while a write is pending
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
        start(4, 0);
        dmem_hold = 1;
        cyc = 0;
        while (!(bus.dmem_req && bus.dmem_we) && cyc < 50) begin
            tick;
            cyc++;
        end
        check_val("t5_in_mwr", bus.dmem_req & bus.dmem_we, 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_dreq_drop", bus.dmem_req, 0);
        check_val("t5_ireq_rst",  bus.imem_req, 0);
        check_val("t5_pc_rst",    pc,           0);
        check_val("t5_no_write",  wr_cnt,       0);
        tick;
        fetches_left = 4;
        dmem_hold    = 0;
        stalled      = 0;
        rst_n        = 1'b1;
        #1;
        check_val("t5_idle",  bus.imem_req,  0);
        tick;
        check_val("t5_fetch", bus.imem_req,  1);
        check_val("t5_faddr", bus.imem_addr, 0);

        // @4 at 4, 0;JMP at 5
        clear_mem();
        rom[0] = 16'h0004; rom[1] = 16'hEA87; rom[4] = 16'h0004; rom[5] = 16'hEA87;
`ifdef HALT_DETECT_EN
        start(50, 0);
        cyc = 0;
        while (!halted && cyc < 100) begin
            tick;
            cyc++;
        end
        check_val("t6_halted", halted, 1);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (bus.imem_req || bus.dmem_req) cyc++;
        end
        check_val("t6_no_req", cyc, 0);
`else
        start(10, 0);
        run_to_stall(200, cyc);
        check_val("t6_halted", halted,        0);
        check_val("t6_pc",     pc,            4);
        check_val("t6_loops",  addr5_fetches, 4);
`endif

        check_val("no_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
